// File: rtl/ascon_loader_pkg.sv
// Shared types and frame layout for the Ascon input loader.
// Frame word indices: SK 0-3, N 4-7, A 8-9, P 10-11.
package ascon_loader_pkg;

  localparam int WORDS = 12;

  localparam logic [3:0] SK_LAST = 4'd3;
  localparam logic [3:0] N_LAST  = 4'd7;
  localparam logic [3:0] A_LAST  = 4'd9;
  localparam logic [3:0] P_LAST  = 4'd11;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_e;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ascon_loader_timer.sv
// Core-latency down-counter: loads on the START cycle, done while the count is zero.
module ascon_loader_timer #(
  parameter int CORE_LATENCY = 45
) (
  input  logic clk,
  input  logic srst,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(CORE_LATENCY + 1);

  logic [CW-1:0] count_q, count_d;

  // Loading LATENCY-1 makes done coincide with the cycle the core output is valid.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CW'(CORE_LATENCY - 1);
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/ascon_input_loader.sv
// Frames 12 input words into SK/N/A/P, launches the encrypt core, returns C/T.
// Optional ASCON_LOADER_BYTESWAP_EN byte-reverses each word before storage.
module ascon_input_loader #(
  parameter int CORE_LATENCY = 45,
  parameter int WORDS        = 12
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [31:0]  IN_DATA,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         IN_LAST,
  output logic [127:0] SK,
  output logic [127:0] N,
  output logic [63:0]  A,
  output logic [63:0]  P,
  output logic         CORE_START,
  input  logic [63:0]  CORE_C,
  input  logic [127:0] CORE_T,
  output logic [63:0]  RES_C,
  output logic [127:0] RES_T,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic         ERR
);

  import ascon_loader_pkg::*;

  localparam int N_BASE = int'(SK_LAST) + 1;
  localparam int A_BASE = int'(N_LAST) + 1;
  localparam int P_BASE = int'(A_LAST) + 1;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         err_q, err_d;
  logic [31:0]  stage_q [WORDS];
  logic [31:0]  stage_d [WORDS];
  logic [31:0]  ops_q   [WORDS];
  logic [31:0]  ops_d   [WORDS];
  logic [63:0]  res_c_q, res_c_d;
  logic [127:0] res_t_q, res_t_d;
  logic [31:0]  word_in;
  logic         timer_load;
  logic         timer_done;

`ifdef ASCON_LOADER_BYTESWAP_EN
  assign word_in = byte_swap32(IN_DATA);
`else
  assign word_in = IN_DATA;
`endif

  ascon_loader_timer #(
    .CORE_LATENCY(CORE_LATENCY)
  ) u_timer (
    .clk  (CLK),
    .srst (RST),
    .load (timer_load),
    .done (timer_done)
  );

  // Words land in a staging buffer; operands only update on a well-framed
  // final word, so a bad frame never disturbs the last good operands.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    stage_d    = stage_q;
    ops_d      = ops_q;
    res_c_d    = res_c_q;
    res_t_d    = res_t_q;
    timer_load = 1'b0;

    case (state_q)
      LOAD: begin
        if (IN_VALID) begin
          if (cnt_q == P_LAST) begin
            cnt_d = 4'd0;
            if (IN_LAST) begin
              ops_d         = stage_q;
              ops_d[P_LAST] = word_in;
              state_d       = START;
            end else begin
              err_d = 1'b1;
            end
          end else if (IN_LAST) begin
            err_d = 1'b1;
            cnt_d = 4'd0;
          end else begin
            stage_d[cnt_q] = word_in;
            cnt_d          = cnt_q + 4'd1;
          end
        end
      end
      START: begin
        timer_load = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (timer_done) begin
          res_c_d = CORE_C;
          res_t_d = CORE_T;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (RES_READY) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      res_c_q <= '0;
      res_t_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        stage_q[i] <= '0;
        ops_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_c_q <= res_c_d;
      res_t_q <= res_t_d;
      stage_q <= stage_d;
      ops_q   <= ops_d;
    end
  end

  // Most significant word first within each operand.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sk
      assign SK[127-32*gi -: 32] = ops_q[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_n
      assign N[127-32*gi -: 32] = ops_q[N_BASE+gi];
    end
    for (gi = 0; gi < 2; gi++) begin : g_a
      assign A[63-32*gi -: 32] = ops_q[A_BASE+gi];
    end
    for (gi = 0; gi < 2; gi++) begin : g_p
      assign P[63-32*gi -: 32] = ops_q[P_BASE+gi];
    end
  endgenerate

  assign IN_READY   = (state_q == LOAD);
  assign CORE_START = (state_q == START);
  assign RES_VALID  = (state_q == RESULT);
  assign RES_C      = res_c_q;
  assign RES_T      = res_t_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_ascon_input_loader.sv
// Scoreboard bench for ascon_input_loader with a fixed-latency core model.
module tb_ascon_input_loader;

  localparam int LAT = 45;

  typedef struct packed {
    logic [127:0] sk;
    logic [127:0] n;
    logic [63:0]  a;
    logic [63:0]  p;
    logic [63:0]  c;
    logic [127:0] t;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [31:0]  IN_DATA = '0;
  logic         IN_VALID = 1'b0;
  logic         IN_LAST = 1'b0;
  logic         IN_READY;
  logic [127:0] SK, N;
  logic [63:0]  A, P;
  logic         CORE_START;
  logic [63:0]  CORE_C = '0;
  logic [127:0] CORE_T = '0;
  logic [63:0]  RES_C;
  logic [127:0] RES_T;
  logic         RES_VALID;
  logic         RES_READY = 1'b0;
  logic         ERR;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  ascon_input_loader #(.CORE_LATENCY(LAT), .WORDS(12)) dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
    .SK(SK), .N(N), .A(A), .P(P), .CORE_START(CORE_START),
    .CORE_C(CORE_C), .CORE_T(CORE_T),
    .RES_C(RES_C), .RES_T(RES_T), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .ERR(ERR)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef ASCON_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [63:0] core_c_fn(input logic [63:0] a, input logic [63:0] p);
    return 64'hDEADBEEFCAFEF00D ^ a ^ 64'h1122334455667788 ^ p ^ 64'hAABBCCDDEEFF0011;
  endfunction

  function automatic logic [127:0] core_t_fn(input logic [127:0] sk, input logic [127:0] n);
    return 128'h0123456789ABCDEF0123456789ABCDEF ^ sk ^ n;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] w [12]);
    exp_t e;
    e.sk = {xf(w[0]), xf(w[1]), xf(w[2]), xf(w[3])};
    e.n  = {xf(w[4]), xf(w[5]), xf(w[6]), xf(w[7])};
    e.a  = {xf(w[8]), xf(w[9])};
    e.p  = {xf(w[10]), xf(w[11])};
    e.c  = core_c_fn(e.a, e.p);
    e.t  = core_t_fn(e.sk, e.n);
    return e;
  endfunction

  // Core model: output valid only during cycle CORE_START+LAT, junk otherwise.
  initial begin
    int cnt;
    logic [127:0] c_sk, c_n;
    logic [63:0]  c_a, c_p;
    cnt = 0;
    c_sk = '0; c_n = '0; c_a = '0; c_p = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            CORE_C = core_c_fn(c_a, c_p);
            CORE_T = core_t_fn(c_sk, c_n);
          end
        end else begin
          CORE_C = {$urandom, $urandom};
          CORE_T = {$urandom, $urandom, $urandom, $urandom};
        end
        if (CORE_START) begin
          cnt = LAT;
          c_sk = SK; c_n = N; c_a = A; c_p = P;
        end
      end
    end
  end

  // Monitor: counts start pulses, pops the scoreboard on each RES_VALID rise.
  initial begin
    bit   rv_prev;
    exp_t m;
    rv_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        rv_prev = 1'b0;
      end else begin
        if (CORE_START) begin
          start_cnt++;
          start_cyc = cyc;
        end
        if (RES_VALID && !rv_prev) begin
          if (exp_q.size() == 0) begin
            check("res_unexpected", 128'(RES_VALID), 128'(0));
          end else begin
            m = exp_q.pop_front();
            check("res_c", 128'(RES_C), 128'(m.c));
            check("res_t", RES_T, m.t);
            check("op_sk", SK, m.sk);
            check("op_n", N, m.n);
            check("op_a", 128'(A), 128'(m.a));
            check("op_p", 128'(P), 128'(m.p));
            check("res_latency", 128'(cyc - start_cyc), 128'(LAT + 1));
            $display("result: C=%h T=%h at cycle %0d", RES_C, RES_T, cyc);
          end
        end
        rv_prev = RES_VALID;
      end
    end
  end

  task automatic send_words(input logic [31:0] w [12], input int n, input int last_at, input bit gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 1000) begin
      @(negedge CLK);
      guard++;
      if (gaps && $urandom_range(1, 0) == 0) begin
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
      end else begin
        IN_VALID = 1'b1;
        IN_DATA  = w[i];
        IN_LAST  = (i == last_at);
        if (IN_READY) i++;
      end
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    check("send_done", 128'(i), 128'(n));
    $display("frame: %0d words sent, last_at=%0d, gaps=%0d", n, last_at, gaps);
  endtask

  task automatic wait_result();
    int k;
    k = 0;
    while (!RES_VALID && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("res_valid_seen", 128'(RES_VALID), 128'(1));
  endtask

  task automatic finish_result(input int hold, input exp_t e);
    RES_READY = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check("hold_valid", 128'(RES_VALID), 128'(1));
      check("hold_c", 128'(RES_C), 128'(e.c));
      check("hold_t", RES_T, e.t);
    end
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    check("rv_drop", 128'(RES_VALID), 128'(0));
    check("ready_after_hs", 128'(IN_READY), 128'(1));
  endtask

  task automatic check_reset_state();
    check("rst_sk", SK, 128'(0));
    check("rst_n", N, 128'(0));
    check("rst_a", 128'(A), 128'(0));
    check("rst_p", 128'(P), 128'(0));
    check("rst_res_c", 128'(RES_C), 128'(0));
    check("rst_res_t", RES_T, 128'(0));
    check("rst_res_valid", 128'(RES_VALID), 128'(0));
    check("rst_core_start", 128'(CORE_START), 128'(0));
    check("rst_err", 128'(ERR), 128'(0));
    check("rst_in_ready", 128'(IN_READY), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w1 [12];
    logic [31:0] w  [12];
    exp_t e1, e;
    int exp_starts;
    exp_starts = 0;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_reset_state();

    // Reference frame, continuous valid, result held off for 10 cycles
    w1 = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
           32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
           32'h11223344, 32'h55667788, 32'hAABBCCDD, 32'hEEFF0011};
    e1 = mk_exp(w1);
    exp_q.push_back(e1);
    send_words(w1, 12, 11, 1'b0);
    check("start_after_w11", 128'(CORE_START), 128'(1));
    exp_starts++;
    @(negedge CLK);
    check("in_ready_wait", 128'(IN_READY), 128'(0));
    IN_VALID = 1'b1; IN_LAST = 1'b1; IN_DATA = 32'hFFFFFFFF;
    repeat (5) @(negedge CLK);
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    wait_result();
    finish_result(10, e1);
    check("err_clean", 128'(ERR), 128'(0));

    // IN_LAST on word 5: frame discarded, ERR set, operands kept
    for (int i = 0; i < 12; i++) w[i] = $urandom;
    send_words(w, 6, 5, 1'b0);
    check("err_early_last", 128'(ERR), 128'(1));
    repeat (3) @(negedge CLK);
    check("no_start_err", 128'(start_cnt), 128'(exp_starts));
    check("keep_sk", SK, e1.sk);
    check("keep_p", 128'(P), 128'(e1.p));

    // Random-valid frame after error; ERR stays set
    for (int i = 0; i < 12; i++) w[i] = $urandom;
    e = mk_exp(w);
    exp_q.push_back(e);
    send_words(w, 12, 11, 1'b1);
    check("start_f2", 128'(CORE_START), 128'(1));
    exp_starts++;
    wait_result();
    finish_result(3, e);
    check("err_sticky", 128'(ERR), 128'(1));

    // Back-to-back frame, reset 20 cycles into WAIT
    for (int i = 0; i < 12; i++) w[i] = $urandom;
    e = mk_exp(w);
    exp_q.push_back(e);
    send_words(w, 12, 11, 1'b0);
    check("start_f3", 128'(CORE_START), 128'(1));
    exp_starts++;
    repeat (20) @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    check_reset_state();
    repeat (60) @(negedge CLK);
    check("no_res_after_rst", 128'(RES_VALID), 128'(0));

    // Word 11 without IN_LAST
    for (int i = 0; i < 12; i++) w[i] = $urandom;
    send_words(w, 12, -1, 1'b0);
    check("err_no_last", 128'(ERR), 128'(1));
    repeat (3) @(negedge CLK);
    check("no_start_nolast", 128'(start_cnt), 128'(exp_starts));
    check("keep_zero_sk", SK, 128'(0));

    // Two more random-valid frames completing normally
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 12; i++) w[i] = $urandom;
      e = mk_exp(w);
      exp_q.push_back(e);
      send_words(w, 12, 11, 1'b1);
      check("start_f4", 128'(CORE_START), 128'(1));
      exp_starts++;
      wait_result();
      finish_result(2, e);
    end

    repeat (3) @(negedge CLK);
    check("start_total", 128'(start_cnt), 128'(exp_starts));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ascon_input_loader.md
ASCON_INPUT_LOADER -- requirements
Module: ascon_input_loader

Interface
REQ-001 SHALL have parameter CORE_LATENCY, default 45, meaning cycles from CORE_START until the encrypt core's C/T outputs are valid.
REQ-002 SHALL have parameter WORDS, default 12, meaning 32-bit words per frame (SK 4, N 4, A 2, P 2); no other value is supported.
REQ-003 SHALL have one clock and a synchronous active-high reset: CLK in 1 (all state on rising edge), RST in 1.
REQ-004 SHALL have ports IN_DATA in 32 (frame word), IN_VALID in 1, IN_READY out 1, IN_LAST in 1 (marks final frame word).
REQ-005 SHALL have ports SK out 128, N out 128, A out 64, P out 64 (registered operands to encrypt core), CORE_START out 1 (one-cycle pulse).
REQ-006 SHALL have ports CORE_C in 64, CORE_T in 128 (core ciphertext/tag).
REQ-007 SHALL have ports RES_C out 64, RES_T out 128, RES_VALID out 1, RES_READY in 1, ERR out 1 (sticky framing error).

Function
REQ-008 SHALL implement FSM states LOAD, START, WAIT, RESULT; reset state LOAD.
REQ-009 LOAD: IN_READY=1; word accepted when IN_VALID&&IN_READY; word counter 0..11 increments per accept.
REQ-010 Word order SHALL be MSW first: words 0-3 -> SK[127:0], 4-7 -> N, 8-9 -> A, 10-11 -> P.
REQ-011 Accepting word 11 with IN_LAST=1 SHALL move to START; counter returns to 0.
REQ-012 IN_LAST=1 on an accepted word other than 11, or IN_LAST=0 on word 11, SHALL set ERR, discard the frame (counter to 0, stay LOAD); SK/N/A/P keep last complete-frame values.
REQ-013 START SHALL last exactly one cycle with CORE_START=1, then WAIT; SK/N/A/P SHALL be stable from START until exit of RESULT.
REQ-014 WAIT SHALL count CORE_LATENCY cycles, then capture CORE_C/CORE_T into RES_C/RES_T and enter RESULT with RES_VALID=1.
REQ-015 RESULT: RES_VALID held with RES_C/RES_T stable until RES_READY=1; on that cycle return to LOAD, RES_VALID=0 next cycle.
REQ-016 IN_READY SHALL be 0 in START, WAIT, RESULT; IN_VALID ignored there.
REQ-017 Back-to-back: first word of next frame may be accepted the cycle after the RES_READY handshake.
REQ-018 ERR SHALL remain 1 until RST; ERR does not block further frames.

Reset
REQ-019 RST=1 at any state, including mid-frame or WAIT, SHALL next cycle give: state LOAD, counter 0, SK/N/A/P/RES_C/RES_T=0, CORE_START=0, RES_VALID=0, ERR=0, IN_READY=1.
REQ-020 A partially loaded frame at reset SHALL be lost; no CORE_START emitted for it.

Configuration
REQ-021 Macro ASCON_LOADER_BYTESWAP_EN defined: each IN_DATA word SHALL be byte-reversed before storage (byte0<->byte3, byte1<->byte2); undefined: stored as received.
REQ-022 Macro SHALL not affect timing, handshake, or word ordering.

Structure
REQ-023 Package ascon_loader_pkg SHALL hold the state enum, WORDS, and word-index field boundaries (SK_LAST=3, N_LAST=7, A_LAST=9, P_LAST=11).
REQ-024 Sub-module ascon_loader_timer SHALL implement the CORE_LATENCY down-counter (load on START, done flag at zero).

Verification
REQ-025 Frame words 0x00010203,0x04050607,0x08090A0B,0x0C0D0E0F, same 4 for N, A 0x11223344,0x55667788, P 0xAABBCCDD,0xEEFF0011, LAST on word 11 -> SK=N=000102030405060708090A0B0C0D0E0F, A=1122334455667788, P=AABBCCDDEEFF0011, CORE_START pulse one cycle after word 11.
REQ-026 Core model drives CORE_C=0xDEADBEEFCAFEF00D, CORE_T=0x0123...CDEF from cycle CORE_START+45 -> RES_VALID rises CORE_START+45+1, values match; RES_READY held 0 for 10 cycles -> outputs stable.
REQ-027 IN_LAST=1 on word 5 -> ERR=1, no CORE_START, subsequent valid frame processed normally with ERR still 1.
REQ-028 RST asserted during WAIT (cycle 20) -> all outputs zero next cycle, no RES_VALID; new frame then completes.
REQ-029 With ASCON_LOADER_BYTESWAP_EN, word 0x00010203 -> SK[127:96]=0x03020100.
REQ-030 IN_VALID toggled randomly 50% during load -> identical operands and single CORE_START per frame.
